// File: rtl/coproc_cmd_issuer_if.sv
// Bundle of the requester, coprocessor and response signals around the command issuer.
// The master modport is the issuer itself (it drives the instruction bus); the slave
// modport is the environment: requester, coprocessor result bus and response consumer.
interface coproc_cmd_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic [29:0] req_op;
    logic [2:0]  req_nwords;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [31:0] instruct;
    logic [31:0] result_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic        err_len;

    modport master (
        input  req_valid, req_op, req_nwords, wr_valid, wr_data, result_in, rsp_ready,
        output req_ready, wr_ready, instruct, rsp_valid, rsp_data, busy, err_len
    );

    modport slave (
        output req_valid, req_op, req_nwords, wr_valid, wr_data, result_in, rsp_ready,
        input  req_ready, wr_ready, instruct, rsp_valid, rsp_data, busy, err_len
    );
endinterface

// File: rtl/coproc_cmd_issuer.sv
// Host-side initiator for the coprocessor instruction bus. Buffers one command
// (header + payload words), serializes it onto instruct, waits a fixed latency,
// samples the coprocessor result and hands it back over a valid/ready port.
module coproc_cmd_issuer #(
    parameter int MAX_WORDS      = 4,
    parameter int HDR_CYCLES     = 2,
    parameter int RESULT_LATENCY = 4
) (
    input logic                 clock,
    input logic                 reset_n,
    coproc_cmd_issuer_if.master bus
);
    // One shared counter width large enough for header, payload and latency counts.
    localparam int MAX_HW  = (HDR_CYCLES > MAX_WORDS) ? HDR_CYCLES : MAX_WORDS;
    localparam int MAX_CNT = (MAX_HW > RESULT_LATENCY) ? MAX_HW : RESULT_LATENCY;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_DATA,
        S_GAP,
        S_WAIT,
        S_RSP
    } state_t;

    state_t           state_q, state_d;
    logic [29:0]      op_q, op_d;
    logic [CNT_W-1:0] nwords_q, nwords_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      word_buf_q [MAX_WORDS];
    logic [31:0]      word_buf_d [MAX_WORDS];
    logic [31:0]      instruct_q, instruct_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             err_len_q, err_len_d;
    logic             len_ok;
    logic [IDX_W-1:0] idx_lo;

    assign len_ok = (bus.req_nwords != 3'd0) && (int'(bus.req_nwords) <= MAX_WORDS);
    assign idx_lo = idx_q[IDX_W-1:0];

    // Next-state and next-output logic; instruct is computed from the current state so
    // the bus lags the state register by exactly one cycle.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        nwords_d    = nwords_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        word_buf_d  = word_buf_q;
        instruct_d  = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        err_len_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (len_ok) begin
                        op_d     = bus.req_op;
                        nwords_d = CNT_W'(bus.req_nwords);
                        idx_d    = '0;
                        state_d  = S_LOAD;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (bus.wr_valid) begin
                    word_buf_d[idx_lo] = bus.wr_data;
                    if (idx_q + CNT_W'(1) == nwords_q) begin
                        cnt_d   = '0;
                        state_d = S_HDR;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            S_HDR: begin
                instruct_d = {2'b01, op_q};
                if (cnt_q == CNT_W'(HDR_CYCLES - 1)) begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                instruct_d = word_buf_q[idx_lo];
                if (idx_q == nwords_q - CNT_W'(1)) begin
                    state_d = S_GAP;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(RESULT_LATENCY - 1)) begin
                    rsp_data_d  = bus.result_in;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the bus immediately and drops any buffered command.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            nwords_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            instruct_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_len_q   <= 1'b0;
            for (int i = 0; i < MAX_WORDS; i++) begin
                word_buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            nwords_q    <= nwords_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            instruct_q  <= instruct_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_len_q   <= err_len_d;
            for (int i = 0; i < MAX_WORDS; i++) begin
                word_buf_q[i] <= word_buf_d[i];
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.wr_ready  = (state_q == S_LOAD);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.instruct  = instruct_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.err_len   = err_len_q;
endmodule

// File: tb/tb_coproc_cmd_issuer.sv
// Bench for coproc_cmd_issuer: a table of directed commands, illegal-length requests,
// a reset-during-DATA sequence and randomized commands checked against a cycle-level
// expectation built from the protocol rules (header count, payload order, fixed latency).
module tb_coproc_cmd_issuer;
    localparam int MAX_WORDS      = 4;
    localparam int HDR_CYCLES     = 2;
    localparam int RESULT_LATENCY = 4;

    typedef struct {
        logic [29:0]                 op;
        int                          nwords;
        logic [MAX_WORDS-1:0][31:0]  words;
        int                          gap;
        logic [31:0]                 rsp_val;
        int                          hold;
        logic [31:0]                 exp_hdr;
        int                          exp_lat;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    int   vectors     = 0;
    int   miscompares = 0;

    coproc_cmd_issuer_if bus();

    coproc_cmd_issuer #(
        .MAX_WORDS     (MAX_WORDS),
        .HDR_CYCLES    (HDR_CYCLES),
        .RESULT_LATENCY(RESULT_LATENCY)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_nwords = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.result_in  = '0;
        bus.rsp_ready  = 1'b0;
    endtask

    // Presents one request for a single clock edge; inputs change at the negedge.
    task automatic applyStimulus(input logic [29:0] op, input logic [2:0] nwords);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_nwords = nwords;
        @(negedge clock);
        bus.req_valid  = 1'b0;
    endtask

    task automatic load_words(input string tag, input int n, input logic [MAX_WORDS-1:0][31:0] w, input int gap);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.wr_valid = 1'b0;
                bus.wr_data  = $urandom;
                @(negedge clock);
                checkOutput($sformatf("%s/load_instr", tag), bus.instruct, 32'h0);
                checkOutput($sformatf("%s/load_wr_ready", tag), bus.wr_ready, 1'b1);
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = w[i];
            @(negedge clock);
        end
        bus.wr_valid = 1'b0;
    endtask

    // Full command: request, load, serialized bus trace, result sampling, response handshake.
    task automatic run_command(input string tag, input logic [29:0] op, input int n,
                               input logic [MAX_WORDS-1:0][31:0] w, input int gap,
                               input logic [31:0] rsp_val, input int hold,
                               input logic [31:0] exp_hdr, input int exp_lat);
        logic [31:0] exp_instr;
        checkOutput($sformatf("%s/req_ready", tag), bus.req_ready, 1'b1);
        applyStimulus(op, 3'(n));
        checkOutput($sformatf("%s/busy_load", tag), bus.busy, 1'b1);
        checkOutput($sformatf("%s/no_err", tag), bus.err_len, 1'b0);
        checkOutput($sformatf("%s/req_ready_load", tag), bus.req_ready, 1'b0);
        load_words(tag, n, w, gap);
        for (int k = 1; k <= exp_lat; k++) begin
            bus.result_in = (k == exp_lat) ? rsp_val : $urandom;
            bus.wr_valid  = 1'($urandom_range(0, 1));
            bus.wr_data   = $urandom;
            @(negedge clock);
            if (k <= HDR_CYCLES)
                exp_instr = exp_hdr;
            else if (k <= HDR_CYCLES + n)
                exp_instr = w[k - HDR_CYCLES - 1];
            else
                exp_instr = 32'h0;
            checkOutput($sformatf("%s/instr%0d", tag, k), bus.instruct, exp_instr);
            checkOutput($sformatf("%s/rsp_valid%0d", tag, k), bus.rsp_valid, (k == exp_lat));
        end
        bus.wr_valid = 1'b0;
        checkOutput($sformatf("%s/rsp_data", tag), bus.rsp_data, rsp_val);
        for (int j = 0; j < hold; j++) begin
            bus.req_valid  = (j == 1);
            bus.req_op     = $urandom;
            bus.req_nwords = 3'd1;
            bus.result_in  = $urandom;
            @(negedge clock);
            checkOutput($sformatf("%s/hold_valid%0d", tag, j), bus.rsp_valid, 1'b1);
            checkOutput($sformatf("%s/hold_data%0d", tag, j), bus.rsp_data, rsp_val);
            checkOutput($sformatf("%s/hold_req_ready%0d", tag, j), bus.req_ready, 1'b0);
            checkOutput($sformatf("%s/hold_instr%0d", tag, j), bus.instruct, 32'h0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        checkOutput($sformatf("%s/rsp_done", tag), bus.rsp_valid, 1'b0);
        checkOutput($sformatf("%s/busy_done", tag), bus.busy, 1'b0);
        checkOutput($sformatf("%s/idle_ready", tag), bus.req_ready, 1'b1);
        checkOutput($sformatf("%s/idle_instr", tag), bus.instruct, 32'h0);
    endtask

    task automatic check_bad_len(input string tag, input logic [2:0] n);
        applyStimulus(30'($urandom), n);
        checkOutput($sformatf("%s/err_pulse", tag), bus.err_len, 1'b1);
        checkOutput($sformatf("%s/err_ready", tag), bus.req_ready, 1'b1);
        checkOutput($sformatf("%s/err_busy", tag), bus.busy, 1'b0);
        checkOutput($sformatf("%s/err_instr", tag), bus.instruct, 32'h0);
        @(negedge clock);
        checkOutput($sformatf("%s/err_single", tag), bus.err_len, 1'b0);
        checkOutput($sformatf("%s/err_idle", tag), bus.busy, 1'b0);
    endtask

    // Main sequence: reset, directed table, illegal lengths, reset abort, random commands.
    initial begin
        vec_t                       vecs [4];
        logic [MAX_WORDS-1:0][31:0] w;
        logic [29:0]                op;
        int                         n;

        vecs[0] = '{30'h4, 1, {96'h0, 32'h00616263}, 0, 32'h0000A5A5, 0, 32'h40000004, 8};
        vecs[1] = '{30'h7, 3, {32'h0, 32'h0, 32'h0, 32'h000000C4}, 0, 32'h12345678, 10, 32'h40000007, 10};
        vecs[2] = '{30'h3FFFFFFF, 4, {32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h11111111}, 2, 32'hDEADBEEF, 1, 32'h7FFFFFFF, 11};
        vecs[3] = '{30'h0, 2, {64'h0, 32'h0, 32'h0}, 1, 32'h0, 3, 32'h40000000, 9};

        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset/instruct", bus.instruct, 32'h0);
        checkOutput("reset/rsp_valid", bus.rsp_valid, 1'b0);
        checkOutput("reset/rsp_data", bus.rsp_data, 32'h0);
        checkOutput("reset/busy", bus.busy, 1'b0);
        checkOutput("reset/err_len", bus.err_len, 1'b0);
        checkOutput("reset/req_ready", bus.req_ready, 1'b1);
        reset_n = 1'b1;
        @(negedge clock);

        for (int v = 0; v < 4; v++) begin
            run_command($sformatf("vec%0d", v), vecs[v].op, vecs[v].nwords, vecs[v].words,
                        vecs[v].gap, vecs[v].rsp_val, vecs[v].hold, vecs[v].exp_hdr, vecs[v].exp_lat);
        end

        check_bad_len("len0", 3'd0);
        check_bad_len("len5", 3'd5);

        // Reset while the second payload word is about to be driven.
        w = {32'hCAFE0004, 32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001};
        applyStimulus(30'h15, 3'd4);
        load_words("rst", 4, w, 0);
        repeat (HDR_CYCLES + 1) @(negedge clock);
        checkOutput("rst/pre_word0", bus.instruct, 32'hCAFE0001);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst/instr_async", bus.instruct, 32'h0);
        checkOutput("rst/busy_async", bus.busy, 1'b0);
        checkOutput("rst/rsp_async", bus.rsp_valid, 1'b0);
        @(negedge clock);
        checkOutput("rst/instr_held", bus.instruct, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        run_command("after_rst", 30'h2A, 2, {64'h0, 32'h0BADF00D, 32'h00000042}, 0,
                    32'h55AA55AA, 0, 32'h4000002A, 9);

        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 4) == 0) begin
                check_bad_len($sformatf("rbad%0d", r), 3'($urandom_range(5, 8) % 8));
            end else begin
                op = 30'($urandom);
                n  = $urandom_range(1, MAX_WORDS);
                for (int i = 0; i < MAX_WORDS; i++)
                    w[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                run_command($sformatf("rnd%0d", r), op, n, w, $urandom_range(0, 2), $urandom,
                            $urandom_range(0, 3), {2'b01, op}, HDR_CYCLES + n + 1 + RESULT_LATENCY);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
